// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM encoding and the bus register map
// used by the baud generator, transmitter and receiver.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

endpackage

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serialiser paced by the baud
// generator's oversampled enable, with a buffer-ready flag for status reads.
module spart_tx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  tx_state_t             state_r, state_nxt_s;
  logic [TW-1:0]         tick_r, tick_nxt_s;
  logic [BW-1:0]         bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0]  hold_r, hold_nxt_s;
  logic [DATA_BITS-1:0]  shift_r, shift_nxt_s;
  logic                  tbr_r, tbr_nxt_s;
  logic                  txd_r, txd_nxt_s;
  logic                  busy_r;
  logic                  wr_s, tick_end_s, load_s;

  assign wr_s       = iocs & ~iorw & (ioaddr == ADDR_DATA);
  assign tick_end_s = baud_en & (tick_r == TICK_LAST);

  // Next-state logic for the frame FSM, counters and the double buffer.
  always_comb begin
    state_nxt_s = state_r;
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    hold_nxt_s  = hold_r;
    tbr_nxt_s   = tbr_r;
    load_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (!tbr_r && baud_en) begin
          load_s      = 1'b1;
          tick_nxt_s  = '0;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (tick_end_s) begin
          tick_nxt_s  = '0;
          bit_nxt_s   = '0;
          state_nxt_s = DATA;
        end else if (baud_en) begin
          tick_nxt_s = tick_r + TW'(1);
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      DATA: begin
        if (tick_end_s) begin
          tick_nxt_s  = '0;
          shift_nxt_s = shift_r >> 1;
          bit_nxt_s   = bit_r + BW'(1);
          if (bit_r == BIT_LAST) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else if (baud_en) begin
          tick_nxt_s = tick_r + TW'(1);
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      STOP: begin
        // A full holding register chains straight into the next start bit.
        if (tick_end_s) begin
          tick_nxt_s = '0;
          if (!tbr_r) begin
            load_s      = 1'b1;
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (baud_en) begin
          tick_nxt_s = tick_r + TW'(1);
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tick_nxt_s  = '0;
        bit_nxt_s   = '0;
      end
    endcase

    // Transfer needs a full buffer and a write needs an empty one, so they never collide.
    if (load_s) begin
      shift_nxt_s = hold_r;
      tbr_nxt_s   = 1'b1;
    end else if (wr_s && tbr_r) begin
      hold_nxt_s = tx_data;
      tbr_nxt_s  = 1'b0;
    end else begin
      hold_nxt_s = hold_r;
      tbr_nxt_s  = tbr_r;
    end
  end

  // Line level follows the state being entered so txd is a clean register output.
  always_comb begin
    txd_nxt_s = 1'b1;
    case (state_nxt_s)
      IDLE:    txd_nxt_s = 1'b1;
      START:   txd_nxt_s = 1'b0;
      DATA:    txd_nxt_s = shift_nxt_s[0];
      STOP:    txd_nxt_s = 1'b1;
      default: txd_nxt_s = 1'b1;
    endcase
  end

  // State, counter, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      tick_r  <= '0;
      bit_r   <= '0;
      hold_r  <= '0;
      shift_r <= '0;
      tbr_r   <= 1'b1;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= tick_nxt_s;
      bit_r   <= bit_nxt_s;
      hold_r  <= hold_nxt_s;
      shift_r <= shift_nxt_s;
      tbr_r   <= tbr_nxt_s;
      txd_r   <= txd_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  assign txd     = txd_r;
  assign tbr     = tbr_r;
  assign tx_busy = busy_r;

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: table-driven write/frame vectors plus
// directed back-to-back, overrun and reset sequences, decoded by a line monitor.
module tb_spart_tx;

  localparam int OS    = 16;
  localparam int BDIV  = 4;
  localparam int BITCK = OS * BDIV;
  localparam int FRMCK = 10 * BITCK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic       txd, tbr, tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         start;
    logic       tbr0;
    logic       busy0;
  } frame_t;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    bit         exp_frame;
    logic [7:0] exp_byte;
  } vec_t;

  frame_t frames[$];
  vec_t   vecs[8];
  logic   smp[FRMCK];

  spart_tx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud_en (baud_en),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .tx_data (tx_data),
    .txd     (txd),
    .tbr     (tbr),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Baud enable: one clk high every BDIV clks, driven on the falling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % BDIV;
      baud_en = (div == 0);
    end
  end

  // Line monitor: captures 10 bit-times from each start edge and decodes them.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && txd === 1'b0) begin : capture
        frame_t f;
        logic   bits[10];
        bit     abort;
        abort   = 1'b0;
        f.start = cyc;
        f.tbr0  = tbr;
        f.busy0 = tx_busy;
        smp[0]  = txd;
        for (int i = 1; i < FRMCK; i++) begin
          @(posedge clk); #1;
          if (rst_n !== 1'b1) abort = 1'b1;
          smp[i] = txd;
        end
        if (!abort) begin
          f.ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            bits[b] = smp[b*BITCK];
            for (int j = 0; j < BITCK; j++)
              if (smp[b*BITCK+j] !== bits[b]) f.ok = 1'b0;
          end
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
          for (int k = 0; k < 8; k++) f.data[k] = bits[k+1];
          frames.push_back(f);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_cycle(input logic cs, input logic rw, input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    iocs = cs; iorw = rw; ioaddr = addr; tx_data = d;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; tx_data = 8'h00;
  endtask

  task automatic wait_frame(input string name, output frame_t f);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * FRMCK && !got; i++) begin
      if (frames.size() > 0) begin
        f   = frames.pop_front();
        got = 1'b1;
      end else begin
        tick(1);
      end
    end
    if (!got) begin
      f = '{data: 8'h00, ok: 1'b0, start: 0, tbr0: 1'b0, busy0: 1'b0};
    end
    check({name, " frame arrived"}, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check({name, " busy seen"}, {31'd0, tx_busy}, 32'd1);
  endtask

  initial begin
    frame_t f1, f2;

    vecs[0] = '{1'b1, 1'b0, 2'b00, 8'hA5, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 8'h77, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 2'b11, 8'h77, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 8'h77, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 8'h77, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 8'h77, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 8'hFF, 1'b1, 8'hFF};

    // Reset with a write strobe held during it.
    rst_n = 1'b0;
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tx_data = 8'h99;
    tick(2);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset tbr", {31'd0, tbr}, 32'd1);
    check("reset busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    iocs = 1'b0; rst_n = 1'b1;
    tick(FRMCK);
    check("reset write ignored frames", frames.size(), 32'd0);
    check("reset write ignored tbr", {31'd0, tbr}, 32'd1);

    // Table of single writes: decode/no-decode and frame content.
    for (int v = 0; v < 8; v++) begin
      bus_cycle(vecs[v].cs, vecs[v].rw, vecs[v].addr, vecs[v].data);
      check($sformatf("vec%0d tbr after write", v), {31'd0, tbr}, {31'd0, ~vecs[v].exp_frame});
      if (vecs[v].exp_frame) begin
        wait_frame($sformatf("vec%0d", v), f1);
        check($sformatf("vec%0d data", v), {24'd0, f1.data}, {24'd0, vecs[v].exp_byte});
        check($sformatf("vec%0d framing", v), {31'd0, f1.ok}, 32'd1);
        check($sformatf("vec%0d tbr at start", v), {31'd0, f1.tbr0}, 32'd1);
        check($sformatf("vec%0d busy at start", v), {31'd0, f1.busy0}, 32'd1);
        tick(1);
        check($sformatf("vec%0d idle after", v), {31'd0, tx_busy}, 32'd0);
      end else begin
        tick(FRMCK + 20);
        check($sformatf("vec%0d no frame", v), frames.size(), 32'd0);
        check($sformatf("vec%0d tbr stays", v), {31'd0, tbr}, 32'd1);
      end
    end

    // Back-to-back: second write lands while the first frame is in DATA.
    bus_cycle(1'b1, 1'b0, 2'b00, 8'h3C);
    tick(120);
    bus_cycle(1'b1, 1'b0, 2'b00, 8'hC3);
    check("b2b tbr after 2nd write", {31'd0, tbr}, 32'd0);
    tick(300);
    check("b2b tbr held low", {31'd0, tbr}, 32'd0);
    wait_frame("b2b first", f1);
    wait_frame("b2b second", f2);
    check("b2b first data", {24'd0, f1.data}, 32'h3C);
    check("b2b second data", {24'd0, f2.data}, 32'hC3);
    check("b2b second framing", {31'd0, f2.ok}, 32'd1);
    check("b2b no gap", f2.start - f1.start, FRMCK);
    check("b2b tbr at 2nd start", {31'd0, f2.tbr0}, 32'd1);
    tick(2);

    // Overrun: third write while the buffer is full is dropped.
    bus_cycle(1'b1, 1'b0, 2'b00, 8'h11);
    wait_busy("ovr");
    tick(10);
    bus_cycle(1'b1, 1'b0, 2'b00, 8'h22);
    bus_cycle(1'b1, 1'b0, 2'b00, 8'h33);
    check("ovr tbr full", {31'd0, tbr}, 32'd0);
    wait_frame("ovr first", f1);
    wait_frame("ovr second", f2);
    check("ovr first data", {24'd0, f1.data}, 32'h11);
    check("ovr second data", {24'd0, f2.data}, 32'h22);
    check("ovr no gap", f2.start - f1.start, FRMCK);
    tick(FRMCK + 20);
    check("ovr third dropped", frames.size(), 32'd0);
    check("ovr tbr empty", {31'd0, tbr}, 32'd1);

    // Reset during data bit 4 of 8'hFF, with a pending byte in the buffer.
    bus_cycle(1'b1, 1'b0, 2'b00, 8'hFF);
    wait_busy("mid");
    bus_cycle(1'b1, 1'b0, 2'b00, 8'hAA);
    tick(5 * BITCK + 16);
    @(negedge clk);
    rst_n = 1'b0;
    tick(1);
    check("mid rst txd", {31'd0, txd}, 32'd1);
    check("mid rst tbr", {31'd0, tbr}, 32'd1);
    check("mid rst busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(FRMCK + 20);
    check("mid rst no frame", frames.size(), 32'd0);
    check("mid rst idle", {31'd0, tx_busy}, 32'd0);
    bus_cycle(1'b1, 1'b0, 2'b00, 8'h55);
    wait_frame("post rst", f1);
    check("post rst data", {24'd0, f1.data}, 32'h55);
    check("post rst framing", {31'd0, f1.ok}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
